// File: rtl/leitura_operandos_if.sv
`default_nettype none
// ============================================================================
// Module      : leitura_operandos_if
// Description : Bundle of the operand-read stage signals: upstream instruction
//               fields with valid/ready, flush, writeback port, and the
//               registered operand/control outputs toward the ALU.
//               master : drives instruction fields, writeback and out_ready
//               slave  : the operand-read stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface leitura_operandos_if #(
    parameter int BITS = 64
);
    // Upstream instruction fields
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [BITS-1:0] imm;
    logic            imediato_in;
    logic            subtraindo_in;
    logic            soma_ou_subtrai_in;
    logic            flush;
    // Writeback port
    logic            we;
    logic [4:0]      waddr;
    logic [BITS-1:0] wdata;
    // Registered outputs toward the ALU
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] dina;
    logic [BITS-1:0] dinb;
    logic [BITS-1:0] constante;
    logic            imediato;
    logic            subtraindo;
    logic            soma_ou_subtrai;
    logic [4:0]      rd_out;

    modport master (
        output in_valid, rs1, rs2, rd, imm, imediato_in, subtraindo_in,
               soma_ou_subtrai_in, flush, we, waddr, wdata, out_ready,
        input  in_ready, out_valid, dina, dinb, constante, imediato,
               subtraindo, soma_ou_subtrai, rd_out
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, imm, imediato_in, subtraindo_in,
               soma_ou_subtrai_in, flush, we, waddr, wdata, out_ready,
        output in_ready, out_valid, dina, dinb, constante, imediato,
               subtraindo, soma_ou_subtrai, rd_out
    );
endinterface
`default_nettype wire

// File: rtl/leitura_operandos.sv
`default_nettype none
// ============================================================================
// Module      : leitura_operandos
// Description : Operand-read stage ahead of the ALU. Holds the 32 x BITS
//               integer register file (x0 hard-wired to zero), reads rs1/rs2
//               with same-cycle writeback bypass, and captures operands and
//               ALU control bits in a one-entry valid/ready pipeline register.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high, clears regfile and pipeline
//               bus   - leitura_operandos_if.slave (handshake, writeback, ALU
//                       operands)
// Revision    : 1.0 - initial release
// ============================================================================
module leitura_operandos #(
    parameter int BITS = 64
) (
    input  wire logic         clk,
    input  wire logic         reset,
    leitura_operandos_if.slave bus
);

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    logic [BITS-1:0] regs_q [32];

    // Writeback ignores the handshake entirely: it commits during stall and
    // flush cycles alike.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.we && (bus.waddr != 5'd0)) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    // Read with bypass so an instruction reading the register being written
    // this same cycle sees the new value rather than the stale entry.
    function automatic logic [BITS-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0) begin
            return '0;
        end else if (bus.we && (bus.waddr == idx)) begin
            return bus.wdata;
        end else begin
            return regs_q[idx];
        end
    endfunction

    logic [BITS-1:0] rs1_val_w;
    logic [BITS-1:0] rs2_val_w;

    always_comb begin
        rs1_val_w = read_reg(bus.rs1);
        rs2_val_w = read_reg(bus.rs2);
    end

    // ------------------------------------------------------------------------
    // Pipeline register with valid/ready handshake
    // ------------------------------------------------------------------------
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] dina_q, dinb_q, constante_q;
    logic            imediato_q, subtraindo_q, soma_ou_subtrai_q;
    logic [4:0]      rd_out_q;

    logic            in_ready_w;
    logic            load_w;

    // Flush blocks acceptance so a flushed cycle can never capture.
    assign in_ready_w = !bus.flush && (!out_valid_q || bus.out_ready);
    assign load_w     = bus.in_valid && in_ready_w;

    // Flush has priority; a load in the same cycle as a consume keeps the
    // register full.
    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (load_w) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    // Payload only changes on load; consume, stall and flush leave the last
    // captured values on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dina_q            <= '0;
            dinb_q            <= '0;
            constante_q       <= '0;
            imediato_q        <= 1'b0;
            subtraindo_q      <= 1'b0;
            soma_ou_subtrai_q <= 1'b0;
            rd_out_q          <= 5'd0;
        end else if (load_w) begin
            dina_q            <= rs1_val_w;
            dinb_q            <= rs2_val_w;
            constante_q       <= bus.imm;
            imediato_q        <= bus.imediato_in;
            subtraindo_q      <= bus.subtraindo_in;
            soma_ou_subtrai_q <= bus.soma_ou_subtrai_in;
            rd_out_q          <= bus.rd;
        end
    end

    assign bus.in_ready        = in_ready_w;
    assign bus.out_valid       = out_valid_q;
    assign bus.dina            = dina_q;
    assign bus.dinb            = dinb_q;
    assign bus.constante       = constante_q;
    assign bus.imediato        = imediato_q;
    assign bus.subtraindo      = subtraindo_q;
    assign bus.soma_ou_subtrai = soma_ou_subtrai_q;
    assign bus.rd_out          = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_leitura_operandos.sv
`default_nettype none
// ============================================================================
// Module      : tb_leitura_operandos
// Description : Self-checking bench for leitura_operandos. A driver applies
//               directed vectors and pushes the expected operand set into a
//               queue whenever an instruction is accepted; a monitor pops and
//               compares each time the ALU side consumes a valid output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leitura_operandos;

    localparam int BITS = 64;

    logic clk;
    logic reset;

    leitura_operandos_if #(.BITS(BITS)) bus ();

    leitura_operandos #(.BITS(BITS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-1:0] c;
        logic            im;
        logic            sub;
        logic            en;
        logic [4:0]      rd;
    } exp_t;

    exp_t            exp_q [$];
    logic [BITS-1:0] m_regs [32];
    logic            m_valid;
    int              n_checks;
    int              n_fail;

    task automatic chk(input string name, input logic [BITS-1:0] act,
                       input logic [BITS-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [BITS-1:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0)                          return '0;
        if (bus.we && (bus.waddr == idx))         return bus.wdata;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle(input logic ordy);
        bus.in_valid           = 1'b0;
        bus.rs1                = 5'd0;
        bus.rs2                = 5'd0;
        bus.rd                 = 5'd0;
        bus.imm                = '0;
        bus.imediato_in        = 1'b0;
        bus.subtraindo_in      = 1'b0;
        bus.soma_ou_subtrai_in = 1'b0;
        bus.flush              = 1'b0;
        bus.we                 = 1'b0;
        bus.waddr              = 5'd0;
        bus.wdata              = '0;
        bus.out_ready          = ordy;
    endtask

    task automatic instr(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rdv, input logic [BITS-1:0] im,
                         input logic [2:0] ctl);
        bus.in_valid           = 1'b1;
        bus.rs1                = r1;
        bus.rs2                = r2;
        bus.rd                 = rdv;
        bus.imm                = im;
        bus.imediato_in        = ctl[2];
        bus.subtraindo_in      = ctl[1];
        bus.soma_ou_subtrai_in = ctl[0];
    endtask

    task automatic wb(input logic [4:0] a, input logic [BITS-1:0] d);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
    endtask

    // One clock cycle: called at posedge+1 after the stimulus is set; returns
    // at the following posedge+1 with the model advanced.
    task automatic step();
        logic exp_rdy;
        logic load;
        exp_t e;
        #1;
        exp_rdy = !bus.flush && (!m_valid || bus.out_ready);
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
        load = bus.in_valid && exp_rdy;
        if (load) begin
            e.a   = m_read(bus.rs1);
            e.b   = m_read(bus.rs2);
            e.c   = bus.imm;
            e.im  = bus.imediato_in;
            e.sub = bus.subtraindo_in;
            e.en  = bus.soma_ou_subtrai_in;
            e.rd  = bus.rd;
            exp_q.push_back(e);
        end
        if (bus.flush && m_valid && (exp_q.size() > 0)) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        if (bus.we && (bus.waddr != 5'd0)) m_regs[bus.waddr] = bus.wdata;
        if (bus.flush)                     m_valid = 1'b0;
        else if (load)                     m_valid = 1'b1;
        else if (m_valid && bus.out_ready) m_valid = 1'b0;
    endtask

    // Monitor: every consumed output must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dina", bus.dina, e.a);
                chk("dinb", bus.dinb, e.b);
                chk("constante", bus.constante, e.c);
                chk("ctrl", {61'd0, bus.imediato, bus.subtraindo, bus.soma_ou_subtrai},
                    {61'd0, e.im, e.sub, e.en});
                chk("rd_out", {59'd0, bus.rd_out}, {59'd0, e.rd});
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        idle(1'b0);
        reset = 1'b1;
        #1;
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_dina", bus.dina, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("reset_constante", bus.constante, 64'd0);
        chk("reset_rd_out", {59'd0, bus.rd_out}, 64'd0);

        // Load from x0 with immediate 5
        idle(1'b1); instr(5'd0, 5'd0, 5'd1, 64'd5, 3'b100); step();
        idle(1'b1); step();

        // Write x3, then read it on both ports
        idle(1'b1); wb(5'd3, 64'h1234); step();
        idle(1'b1); instr(5'd3, 5'd3, 5'd4, 64'd0, 3'b001); step();
        // Write to x0 is ignored
        idle(1'b1); wb(5'd0, 64'hFF); step();
        idle(1'b1); instr(5'd0, 5'd3, 5'd5, 64'd7, 3'b011); step();

        // Same-cycle bypass on rs2
        idle(1'b1); wb(5'd7, 64'hABCD); instr(5'd3, 5'd7, 5'd6, 64'h10, 3'b111); step();

        // Back-pressure: hold A, rewrite x3 during the stall
        idle(1'b1); instr(5'd3, 5'd7, 5'd8, 64'h20, 3'b010); step();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0); instr(5'd3, 5'd0, 5'd9, 64'h30, 3'b001); wb(5'd3, 64'h9999);
            step();
            chk("stall_dina_held", bus.dina, 64'h1234);
        end
        idle(1'b1); instr(5'd3, 5'd7, 5'd9, 64'h30, 3'b001); step();
        idle(1'b1); step();

        // Flush with a held entry and a pending instruction; writeback commits
        idle(1'b0); instr(5'd7, 5'd3, 5'd10, 64'h40, 3'b100); step();
        idle(1'b0); instr(5'd3, 5'd3, 5'd11, 64'h50, 3'b111); wb(5'd9, 64'h55);
        bus.flush = 1'b1; step();
        idle(1'b1); instr(5'd9, 5'd0, 5'd12, 64'h60, 3'b000); step();
        idle(1'b1); step();

        // Back-to-back throughput
        idle(1'b1); instr(5'd3, 5'd9, 5'd13, 64'h1, 3'b001); step();
        idle(1'b1); instr(5'd7, 5'd3, 5'd14, 64'h2, 3'b010); step();
        idle(1'b1); instr(5'd9, 5'd7, 5'd15, 64'h3, 3'b100); step();
        idle(1'b1); step();

        // Asynchronous reset mid-stream
        idle(1'b0); instr(5'd9, 5'd3, 5'd16, 64'h77, 3'b111); step();
        #2;
        reset = 1'b1;
        #1;
        chk("areset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("areset_dina", bus.dina, 64'd0);
        chk("areset_dinb", bus.dinb, 64'd0);
        chk("areset_constante", bus.constante, 64'd0);
        chk("areset_ctrl", {61'd0, bus.imediato, bus.subtraindo, bus.soma_ou_subtrai}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b1); instr(5'd9, 5'd3, 5'd17, 64'h8, 3'b000); step();
        idle(1'b1); step();
        idle(1'b1); step();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
